// File: rtl/fp_adder_arbiter.sv
// -----------------------------------------------------------------------------
// fp_adder_arbiter
//
// Purpose:
//   Shares one combinational single-precision floating-point adder among
//   N_REQ requesters. A round-robin arbiter grants one pending requester,
//   the granted operand pair is registered, the adder result is captured
//   one cycle later, and the result is presented with the requester index
//   on a single valid/ready response channel.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   req_valid    [N_REQ]    requester i has an operand pair pending
//   req_ready    [N_REQ]    one-hot (or zero) accept, combinational in IDLE
//   req_a        [32*N_REQ] operand A, requester i at [32*i +: 32]
//   req_b        [32*N_REQ] operand B, same packing
//   rsp_valid    result held and valid
//   rsp_ready    consumer accepts the result
//   rsp_sum      [32] registered adder Sum
//   rsp_cout     registered adder Cout
//   rsp_overflow registered adder Overflow
//   rsp_id       [ID_W] requester that owns the result
//   busy         high whenever the sequencer is not idle
//
// Also contains floating_point_adder, the combinational datapath:
//   A, B      [32] IEEE-754 single-precision operands
//   Sum       [32] truncated sum (denormals flushed to zero)
//   Cout      carry out of the aligned mantissa addition
//   Overflow  result exponent saturated to infinity
// -----------------------------------------------------------------------------

module floating_point_adder (
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic [31:0] Sum,
   output logic        Cout,
   output logic        Overflow
);

   logic [31:0]       w_big;
   logic [31:0]       w_small;
   logic [7:0]        w_e_big;
   logic [7:0]        w_e_small;
   logic [7:0]        w_e_diff;
   logic [23:0]       w_m_big;
   logic [23:0]       w_m_small;
   logic [23:0]       w_m_shift;
   logic              w_eff_sub;
   logic [24:0]       w_raw;
   logic [4:0]        w_lz;
   logic signed [9:0] w_exp_n;
   logic [23:0]       w_mant;

   // Leading-zero count of a 24-bit mantissa; 24 when the value is zero.
   function automatic logic [4:0] f_lzc24(input logic [23:0] v);
      logic [4:0] n;
      n = 5'd24;
      for (int i = 0; i < 24; i++) begin
         if (v[i]) begin
            n = 5'(23 - i);
         end else begin
            n = n;
         end
      end
      return n;
   endfunction

   // Align the smaller-magnitude operand, add/subtract, normalise, pack.
   always_comb begin
      // Order by magnitude so the subtraction below never goes negative.
      if (A[30:0] >= B[30:0]) begin
         w_big   = A;
         w_small = B;
      end else begin
         w_big   = B;
         w_small = A;
      end
      w_e_big   = w_big[30:23];
      w_e_small = w_small[30:23];
      // Exponent zero is treated as zero (no denormal support).
      w_m_big   = (w_e_big   != 8'd0) ? {1'b1, w_big[22:0]}   : 24'd0;
      w_m_small = (w_e_small != 8'd0) ? {1'b1, w_small[22:0]} : 24'd0;
      w_e_diff  = w_e_big - w_e_small;
      // Alignment truncates the bits shifted out.
      w_m_shift = (w_e_diff > 8'd23) ? 24'd0 : (w_m_small >> w_e_diff);
      w_eff_sub = w_big[31] ^ w_small[31];
      if (w_eff_sub) begin
         w_raw = {1'b0, w_m_big} - {1'b0, w_m_shift};
      end else begin
         w_raw = {1'b0, w_m_big} + {1'b0, w_m_shift};
      end
      w_lz = f_lzc24(w_raw[23:0]);
      if (w_raw[24]) begin
         w_exp_n = $signed({2'b00, w_e_big}) + 10'sd1;
         w_mant  = w_raw[24:1];
      end else begin
         w_exp_n = $signed({2'b00, w_e_big}) - $signed({5'b00000, w_lz});
         w_mant  = w_raw[23:0] << w_lz;
      end

      Cout     = ~w_eff_sub & w_raw[24];
      Overflow = 1'b0;
      if (w_e_big == 8'hFF) begin
         // Infinity/NaN operand: pass the larger-magnitude operand through.
         Sum = w_big;
      end else if (w_raw == 25'd0) begin
         Sum = 32'd0;
      end else if (w_exp_n >= 10'sd255) begin
         Sum      = {w_big[31], 8'hFF, 23'd0};
         Overflow = 1'b1;
      end else if (w_exp_n <= 10'sd0) begin
         Sum = 32'd0;
      end else begin
         Sum = {w_big[31], w_exp_n[7:0], w_mant[22:0]};
      end
   end

endmodule

module fp_adder_arbiter #(
   parameter int N_REQ = 4,
   parameter int ID_W  = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [N_REQ-1:0]      req_valid,
   output logic [N_REQ-1:0]      req_ready,
   input  logic [32*N_REQ-1:0]   req_a,
   input  logic [32*N_REQ-1:0]   req_b,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [31:0]           rsp_sum,
   output logic                  rsp_cout,
   output logic                  rsp_overflow,
   output logic [ID_W-1:0]       rsp_id,
   output logic                  busy
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [ID_W-1:0] r_rr_ptr;
   logic [31:0]     r_op_a;
   logic [31:0]     r_op_b;
   logic [31:0]     r_rsp_sum;
   logic            r_rsp_cout;
   logic            r_rsp_ovf;
   logic [ID_W-1:0] r_rsp_id;
   logic            r_rsp_valid;
   logic            r_busy;

   logic            w_grant_vld;
   logic [ID_W-1:0] w_grant_id;
   logic [ID_W-1:0] w_ptr_nxt;
   logic            w_accept;
   logic [31:0]     w_sum;
   logic            w_cout;
   logic            w_ovf;

   // Round-robin search starting at r_rr_ptr, wrapping modulo N_REQ.
   always_comb begin
      logic [ID_W:0] idx;
      w_grant_vld = 1'b0;
      w_grant_id  = '0;
      // Walk from the farthest offset down so the nearest valid one wins.
      for (int off = N_REQ - 1; off >= 0; off--) begin
         idx = {1'b0, r_rr_ptr} + (ID_W+1)'(off);
         if (idx >= (ID_W+1)'(N_REQ)) begin
            idx = idx - (ID_W+1)'(N_REQ);
         end else begin
            idx = idx;
         end
         if (req_valid[idx[ID_W-1:0]]) begin
            w_grant_vld = 1'b1;
            w_grant_id  = idx[ID_W-1:0];
         end else begin
            w_grant_vld = w_grant_vld;
         end
      end
      if (w_grant_id == ID_W'(N_REQ - 1)) begin
         w_ptr_nxt = '0;
      end else begin
         w_ptr_nxt = w_grant_id + ID_W'(1);
      end
   end

   // Next-state and combinational request acceptance.
   always_comb begin
      w_state_nxt = r_state;
      req_ready   = '0;
      w_accept    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_grant_vld) begin
               w_accept    = 1'b1;
               req_ready   = N_REQ'(1) << w_grant_id;
               w_state_nxt = ST_EXEC;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_EXEC: begin
            w_state_nxt = ST_RESP;
         end
         ST_RESP: begin
            if (rsp_ready) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_state_nxt = ST_RESP;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // State register plus registered status flags derived from next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_rsp_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_rsp_valid <= (w_state_nxt == ST_RESP);
         r_busy      <= (w_state_nxt != ST_IDLE);
      end
   end

   // Operand capture on a grant, result capture in EXEC only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rr_ptr   <= '0;
         r_op_a     <= 32'd0;
         r_op_b     <= 32'd0;
         r_rsp_id   <= '0;
         r_rsp_sum  <= 32'd0;
         r_rsp_cout <= 1'b0;
         r_rsp_ovf  <= 1'b0;
      end else begin
         if (w_accept) begin
            r_op_a   <= req_a[{w_grant_id, 5'd0} +: 32];
            r_op_b   <= req_b[{w_grant_id, 5'd0} +: 32];
            r_rsp_id <= w_grant_id;
            r_rr_ptr <= w_ptr_nxt;
         end
         if (r_state == ST_EXEC) begin
            r_rsp_sum  <= w_sum;
            r_rsp_cout <= w_cout;
            r_rsp_ovf  <= w_ovf;
         end
      end
   end

   floating_point_adder u_fpa (
      .A        (r_op_a),
      .B        (r_op_b),
      .Sum      (w_sum),
      .Cout     (w_cout),
      .Overflow (w_ovf)
   );

   assign rsp_valid    = r_rsp_valid;
   assign busy         = r_busy;
   assign rsp_sum      = r_rsp_sum;
   assign rsp_cout     = r_rsp_cout;
   assign rsp_overflow = r_rsp_ovf;
   assign rsp_id       = r_rsp_id;

endmodule

// File: doc/fp_adder_arbiter.md
Name: fp_adder_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one combinational floating_point_adder instance (ports A, B, Sum, Cout, Overflow) among N_REQ requesters.
- Each requester presents an IEEE-754 single-precision operand pair on a valid/ready handshake.
- The block grants one requester, registers its operands, evaluates the adder for one cycle, and returns the registered result with the requester ID on one shared valid/ready response channel.
- It sits between the ALU issue logic and the FP adder datapath.

Parameters:
- N_REQ, 4, number of requesters; legal range 2..8.
- ID_W, 2, width of the requester index; must equal clog2(N_REQ).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  N_REQ  bit i set: requester i has an operand pair pending.
- req_ready  output  N_REQ  one-hot or zero; bit i set: requester i's operands are accepted this cycle.
- req_a  input  32*N_REQ  operand A; requester i uses bits [32*i+31 : 32*i].
- req_b  input  32*N_REQ  operand B; same packing as req_a.
- rsp_valid  output  1  result held and valid.
- rsp_ready  input  1  consumer accepts the result.
- rsp_sum  output  32  registered Sum from floating_point_adder.
- rsp_cout  output  1  registered Cout.
- rsp_overflow  output  1  registered Overflow.
- rsp_id  output  ID_W  index of the requester that owns the result.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (async assert, rst_n low):
  - state = IDLE; rr_ptr = 0.
  - op_a, op_b, rsp_sum = 0; rsp_cout, rsp_overflow = 0; rsp_id = 0.
  - rsp_valid = 0; req_ready = 0; busy = 0.
- Reset deassertion is synchronised externally; no reset synchroniser inside the block.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant = first i with req_valid[i] = 1, searching rr_ptr, rr_ptr+1, ..., wrapping modulo N_REQ.
  - req_ready[grant] = 1 combinationally in the same cycle; all other req_ready bits = 0.
  - If no request is pending, req_ready = 0 and the FSM stays in IDLE.
  - On a grant edge: op_a <= req_a[grant], op_b <= req_b[grant], rsp_id <= grant, rr_ptr <= (grant+1) mod N_REQ, go to EXEC.
- EXEC:
  - Adder A = op_a, B = op_b.
  - On the edge: rsp_sum <= Sum, rsp_cout <= Cout, rsp_overflow <= Overflow, go to RESP.
  - req_ready = 0.
- RESP:
  - rsp_valid = 1. rsp_sum, rsp_cout, rsp_overflow and rsp_id are held stable until the handshake.
  - When rsp_ready = 1: go to IDLE. rsp_valid deasserts the following cycle.
  - req_ready = 0.
- Outside EXEC, the adder inputs keep op_a/op_b; output registers load only in EXEC.
- Latency:
  - Request accept edge to rsp_valid high: 2 cycles.
  - Minimum issue interval: 3 cycles, when rsp_ready is held high.
- Fairness: rr_ptr advances only on a grant. A requester held valid is granted within N_REQ grants.
- Handshake rules:
  - A requester must hold req_valid and its operands until it sees req_ready.
  - req_valid may drop without a grant; no request is captured then.
  - req_ready never asserts while busy.
- Simultaneous requests: all N_REQ valid with rr_ptr = k -> grant k.
- Wrap-around: rr_ptr = N_REQ-1 with a grant -> rr_ptr = 0.
- Backpressure: rsp_ready low indefinitely -> the FSM stays in RESP, outputs are stable, no new grants.
- rsp_ready high outside RESP: ignored.
- Reset mid-operation (EXEC or RESP): the in-flight result is dropped, the FSM returns to IDLE, and rsp_valid = 0 immediately (asynchronously).
- No arithmetic is performed in this block. Sum, Cout and Overflow pass through unmodified from floating_point_adder.

Test Plan:
- Reset then idle: rst_n low 2 cycles, no req_valid -> all outputs 0, busy = 0, req_ready = 0 for 10 cycles.
- Single request: requester 2 sends A = 32'hBE99999A, B = 32'h43FA2000.
  - req_ready[2] = 1 in the same cycle.
  - 2 cycles later: rsp_valid = 1, rsp_sum = 32'h43F9F99A, rsp_cout = 0, rsp_overflow = 0, rsp_id = 2.
- Round-robin: all 4 requesters valid continuously with A = 32'h3F800000, B = 32'h40000000, rsp_ready = 1.
  - Grants in order 0, 1, 2, 3, 0, one every 3 cycles.
  - Each rsp_sum = 32'h40400000 with the matching rsp_id.
- Backpressure: rsp_ready = 0 for 8 cycles during RESP.
  - rsp_valid stays 1 with stable data; req_ready stays 0 despite pending requests.
  - The next grant comes 1 cycle after rsp_ready rises and the FSM returns to IDLE.
- Wrap and skip: rr_ptr = 3 with only requester 1 valid -> grant 1, rr_ptr becomes 2. Next, requesters 0 and 3 valid -> grant 3.
- Reset mid-operation: assert rst_n low during EXEC.
  - rsp_valid = 0 and busy = 0 immediately.
  - After release, no stale response appears and the first grant goes to requester 0.
